// File: rtl/soc_pio_in_edge.sv
// Avalon-MM input PIO with synchroniser, per-bit edge capture and maskable level irq.
// Optional per-bit debounce is compiled in with `define PIO_IN_DEBOUNCE_EN.
module soc_pio_in_edge #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned EDGE_TYPE       = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] clr;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

`ifdef PIO_IN_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

  logic [CntW-1:0]  cnt_q [WIDTH];
  logic [CntW-1:0]  cnt_d [WIDTH];
  logic [WIDTH-1:0] level_q, level_d;

  // A bit's counter runs only while sync2 disagrees with the accepted level.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] + CntW'(1) == CntMax) begin
          level_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      level_q <= level_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign level = level_q;
`else
  localparam int unsigned unused_debounce = DEBOUNCE_CYCLES;
  assign level = sync2_q;
`endif

  if (EDGE_TYPE == 0) begin : g_rise
    assign edge_vec = level & ~prev_q;
  end else if (EDGE_TYPE == 1) begin : g_fall
    assign edge_vec = ~level & prev_q;
  end else begin : g_any
    assign edge_vec = level ^ prev_q;
  end

  if (WIDTH < 32) begin : g_wd_unused
    logic unused_wd;
    assign unused_wd = ^writedata[31:WIDTH];
  end

  assign wr_en = chipselect & write;

  always_comb begin
    clr = '0;
    if (wr_en && address == 2'd3) begin
      clr = writedata[WIDTH-1:0];
    end
    // Set has priority over a simultaneous W1C.
    cap_d  = (cap_q & ~clr) | edge_vec;
    mask_d = mask_q;
    if (wr_en && address == 2'd2) begin
      mask_d = writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = level;
      2'd2:    readdata_d[WIDTH-1:0] = mask_q;
      2'd3:    readdata_d[WIDTH-1:0] = cap_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q     <= '0;
      cap_q      <= '0;
      mask_q     <= '0;
      readdata_q <= '0;
    end else begin
      prev_q     <= level;
      cap_q      <= cap_d;
      mask_q     <= mask_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: doc/soc_pio_in_edge.md
# soc_pio_in_edge

Parametrised Avalon-MM input PIO slave. It is the next generation of the fixed 8-bit input port and sits between board-level switch/button pins and the HPS/Nios lightweight bus. It adds an input synchroniser, per-bit edge capture, a maskable level interrupt and optional debounce. Readdata keeps the registered, 1-cycle-latency behaviour of the existing input ports.

## Interface
Parameters:
- WIDTH, 8: input bits, 1..32; readdata is zero-extended above WIDTH.
- EDGE_TYPE, 0: edge detected per bit; 0 = rising, 1 = falling, 2 = any.
- DEBOUNCE_CYCLES, 16: stable cycles required before a level is accepted, ≥1. Used only when debounce is compiled in.

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: reset, asynchronous, active-low.
- address, in, 2: register select.
- chipselect, in, 1: slave select; qualifies write.
- write, in, 1: write strobe; active only with chipselect.
- writedata, in, 32: write data; bits above WIDTH are ignored.
- in_port, in, WIDTH: asynchronous external inputs.
- readdata, out, 32: registered read data.
- irq, out, 1: level interrupt, active-high.

## Operation
- Synchroniser: two flops per bit, sync1 then sync2.
- level: the accepted input value. It equals sync2 when debounce is compiled out, otherwise the debounced value.
- prev: level delayed by one clk.
- edge vector, per EDGE_TYPE:
  - 0: level & ~prev
  - 1: ~level & prev
  - 2: level ^ prev
- Register map (address):
  - 0 DATA, RO: level. Writes are ignored.
  - 1 reserved: reads 0. Writes are ignored.
  - 2 IRQ_MASK, RW, WIDTH bits.
  - 3 EDGE_CAP, R/W1C: a bit sets on an edge and clears when written with 1.
- EDGE_CAP update each cycle: cap <= (cap & ~clr) | edge, where clr = writedata when chipselect & write & address==3, else 0.
- Set and clear of the same bit in the same cycle: set wins, bit stays 1.
- irq = |(EDGE_CAP & IRQ_MASK). It is combinational from registers and glitch-free.
- readdata <= zero-extended mux(address) on every clk. No read strobe is needed and reads have no side effects.
- Reset clears sync1, sync2, level, prev, EDGE_CAP, IRQ_MASK and debounce counters. readdata = 0 and irq = 0 during and after reset.
- An input already high at reset release propagates as a rising edge. This is intended: software clears EDGE_CAP at init.
- Reset asserted mid-debounce discards the partial count.

## Timing
- in_port stable before edge k:
  - sync1 at k, sync2 at k+1.
  - level = sync2 with debounce compiled out.
  - EDGE_CAP set at k+2.
  - irq high after k+2 if the bit is masked in.
- DATA visible on readdata one cycle after address=0 is presented, i.e. edge k+2 for an input change at k.
- Register writes take effect at the clk edge where chipselect & write are sampled. A readback of the new value is valid on the following cycle.
- Write of IRQ_MASK and irq: a new mask affects irq in the same cycle it is registered.
- Debounce compiled in: level changes DEBOUNCE_CYCLES clks after sync2 first differs from level, provided sync2 holds the new value continuously.

## Configuration
- Macro: PIO_IN_DEBOUNCE_EN.
- Defined:
  - Each bit has a counter, width = clog2(DEBOUNCE_CYCLES+1).
  - While sync2 != level the counter increments; when it reaches DEBOUNCE_CYCLES, level <= sync2 and the counter clears.
  - sync2 == level clears the counter, so glitches shorter than DEBOUNCE_CYCLES never reach level.
- Not defined: no counters; level = sync2. DEBOUNCE_CYCLES is ignored.

## Test plan
- Reset, in_port = 8'h00: readdata = 0, irq = 0. Read address 2 and address 3: both 0.
- EDGE_TYPE = 0, mask = 8'h01, in_port 0→8'h01 at edge k: DATA reads 8'h01 at k+2, EDGE_CAP = 8'h01, irq = 1. Write 8'h01 to address 3: irq = 0 next cycle.
- Edge on bit 3 in the same cycle as a W1C write of 8'h08 to address 3: EDGE_CAP bit 3 = 1, set wins.
- Mask = 0, edge on bit 5: EDGE_CAP = 8'h20 and irq = 0. Then write mask 8'h20: irq = 1 in the following cycle.
- EDGE_TYPE = 2: toggle bit 0 high then low. EDGE_CAP bit 0 sets on both edges and survives until cleared. Address 1 reads 0.
- PIO_IN_DEBOUNCE_EN, DEBOUNCE_CYCLES = 16:
  - 10-cycle pulse on bit 2: DATA stays 0 and no capture.
  - 30-cycle pulse: DATA goes 8'h04 exactly 16 clks after sync2 changes, and EDGE_CAP bit 2 sets.
